// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the pipeline controller (FORWARDING_EN selects the forwarding build).
package pipeline_controller_pkg;

  localparam int unsigned REG_W = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
  localparam logic [SEL_W-1:0] FWD_MEM = 2'b01;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

  // A source collides with a stage when it is really read and that stage writes the same register.
  function automatic logic src_hit(input logic [REG_W-1:0] idx, input logic use_bit,
                                   input logic [REG_W-1:0] dest, input logic wb_en);
    return use_bit & wb_en & (dest == idx);
  endfunction

  // MEM is younger than WB, so its result wins.
  function automatic logic [SEL_W-1:0] fwd_pick(input logic [REG_W-1:0] src,
                                                input logic [REG_W-1:0] mem_dest, input logic mem_wb_en,
                                                input logic [REG_W-1:0] wb_dest, input logic wb_wb_en);
    if (mem_wb_en && (mem_dest == src)) return FWD_MEM;
    if (wb_wb_en && (wb_dest == src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational RAW stall and operand-forwarding selects; FORWARDING_EN reduces stalls to load-use.
module pipeline_controller_hazard_detect
  import pipeline_controller_pkg::*;
(
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_use_src1,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] exe_src1,
  input  logic [REG_W-1:0] exe_src2,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  output logic             raw_stall_c,
  output logic [SEL_W-1:0] fwd_sel1_c,
  output logic [SEL_W-1:0] fwd_sel2_c
);

  logic exe_hit;
  assign exe_hit = src_hit(id_src1, id_use_src1, exe_dest, exe_wb_en)
                 | src_hit(id_src2, id_two_src,  exe_dest, exe_wb_en);

`ifdef FORWARDING_EN
  assign raw_stall_c = exe_hit & exe_mem_r_en;
  assign fwd_sel1_c  = fwd_pick(exe_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
  assign fwd_sel2_c  = fwd_pick(exe_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
`else
  logic mem_hit;
  logic unused_fwd;
  assign mem_hit = src_hit(id_src1, id_use_src1, mem_dest, mem_wb_en)
                 | src_hit(id_src2, id_two_src,  mem_dest, mem_wb_en);
  assign raw_stall_c = exe_hit | mem_hit;
  assign fwd_sel1_c  = FWD_RF;
  assign fwd_sel2_c  = FWD_RF;
  // Forwarding inputs stay on the port list for a uniform interface.
  assign unused_fwd  = ^{exe_src1, exe_src2, wb_dest, wb_wb_en, exe_mem_r_en};
`endif

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline freeze/flush/bubble sequencing with SRAM handshake FSM; FORWARDING_EN enables operand forwarding.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_use_src1,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] exe_src1,
  input  logic [REG_W-1:0] exe_src2,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  input  logic             exe_b,
  output logic             sram_start,
  output logic             freeze_all,
  output logic             hazard_stall,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             mem_timeout
);

  mem_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             raw_stall_c;

  pipeline_controller_hazard_detect u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_use_src1  (id_use_src1),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_src1     (exe_src1),
    .exe_src2     (exe_src2),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .wb_dest      (wb_dest),
    .wb_wb_en     (wb_wb_en),
    .raw_stall_c  (raw_stall_c),
    .fwd_sel1_c   (fwd_sel1),
    .fwd_sel2_c   (fwd_sel2)
  );

  // SRAM handshake; the timeout forces DONE so a lost mem_ready cannot deadlock the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (mem_ready) begin
            state <= DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= DONE;
            mem_timeout <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request and freeze react to mem_req in the issue cycle; reset drops them at once.
  always_comb begin
    sram_start = 1'b0;
    freeze_all = 1'b0;
    case (state)
      IDLE: begin
        sram_start = mem_req;
        freeze_all = mem_req;
      end
      WAIT:    freeze_all = 1'b1;
      default: ;
    endcase
    if (rst) begin
      sram_start = 1'b0;
      freeze_all = 1'b0;
    end
  end

  assign flush        = exe_b & ~freeze_all;
  assign hazard_stall = raw_stall_c & ~freeze_all & ~exe_b;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller; honours FORWARDING_EN for the expected behaviour.
`timescale 1ns/1ps
module tb_pipeline_controller;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, exe_src1, exe_src2, mem_dest, wb_dest;
  logic       id_two_src, id_use_src1, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       mem_req, mem_ready, wb_wb_en, exe_b;
  logic       sram_start, freeze_all, hazard_stall, flush, mem_timeout;
  logic [1:0] fwd_sel1, fwd_sel2;

  int tests = 0;
  int fails = 0;

  // Reference model: an in-flight access, how long it has waited, and the one-cycle release.
  bit busy, release_cyc, m_timeout;
  int waited;

  always #5 clk = ~clk;

  pipeline_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_use_src1(id_use_src1),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_src1(exe_src1), .exe_src2(exe_src2),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .exe_b(exe_b),
    .sram_start(sram_start), .freeze_all(freeze_all), .hazard_stall(hazard_stall),
    .flush(flush), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .mem_timeout(mem_timeout)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic u, input logic en, input logic [3:0] d, input logic [3:0] i);
    return u && en && (d == i);
  endfunction

  task automatic zero_inputs();
    {id_src1, id_src2, exe_dest, exe_src1, exe_src2, mem_dest, wb_dest} = '0;
    {id_two_src, id_use_src1, exe_wb_en, exe_mem_r_en, mem_wb_en} = '0;
    {mem_req, mem_ready, wb_wb_en, exe_b} = '0;
  endtask

  task automatic model_reset();
    busy = 0; release_cyc = 0; m_timeout = 0; waited = 0;
  endtask

  task automatic model_advance();
    if (release_cyc) begin
      release_cyc = 0;
    end else if (busy) begin
      waited++;
      if (mem_ready || waited == TIMEOUT) begin
        if (!mem_ready) m_timeout = 1;
        busy = 0;
        release_cyc = 1;
      end
    end else if (mem_req) begin
      busy = 1;
      waited = 0;
    end
  endtask

  // Called at a falling edge with inputs applied: check every output, then advance one cycle.
  task automatic tick(input string tag);
    bit e_start, e_freeze, raw_exe, raw;
    logic [1:0] e1, e2;
`ifndef FORWARDING_EN
    bit raw_mem;
`endif
    #1;
    e_start  = !rst && !busy && !release_cyc && mem_req;
    e_freeze = !rst && (busy || e_start);
    raw_exe  = hit(id_use_src1, exe_wb_en, exe_dest, id_src1) || hit(id_two_src, exe_wb_en, exe_dest, id_src2);
`ifdef FORWARDING_EN
    raw = raw_exe && exe_mem_r_en;
    e1 = (mem_wb_en && mem_dest == exe_src1) ? 2'b01 : (wb_wb_en && wb_dest == exe_src1) ? 2'b10 : 2'b00;
    e2 = (mem_wb_en && mem_dest == exe_src2) ? 2'b01 : (wb_wb_en && wb_dest == exe_src2) ? 2'b10 : 2'b00;
`else
    raw_mem = hit(id_use_src1, mem_wb_en, mem_dest, id_src1) || hit(id_two_src, mem_wb_en, mem_dest, id_src2);
    raw = raw_exe || raw_mem;
    e1 = 2'b00;
    e2 = 2'b00;
`endif
    chk({tag, ".sram_start"},   8'(sram_start),   8'(e_start));
    chk({tag, ".freeze_all"},   8'(freeze_all),   8'(e_freeze));
    chk({tag, ".flush"},        8'(flush),        8'(exe_b && !e_freeze));
    chk({tag, ".hazard_stall"}, 8'(hazard_stall), 8'(raw && !e_freeze && !exe_b));
    chk({tag, ".fwd_sel1"},     8'(fwd_sel1),     8'(e1));
    chk({tag, ".fwd_sel2"},     8'(fwd_sel2),     8'(e2));
    chk({tag, ".mem_timeout"},  8'(mem_timeout),  8'(m_timeout));
    @(posedge clk);
    if (!rst) model_advance();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_start, n_freeze;
    rst = 1'b1;
    zero_inputs();
    model_reset();
    @(negedge clk);
    tick("reset");
    tick("reset");
    rst = 1'b0;
    tick("idle");

    // RAW hazard against EXE, non-load
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b0;
    #1;
`ifdef FORWARDING_EN
    chk("raw_exe_alu", 8'(hazard_stall), 8'd0);
`else
    chk("raw_exe_alu", 8'(hazard_stall), 8'd1);
`endif
    tick("raw_exe_alu");
    exe_mem_r_en = 1'b1;
    #1;
    chk("raw_exe_load", 8'(hazard_stall), 8'd1);
    tick("raw_exe_load");
    id_use_src1 = 1'b0;
    tick("raw_no_use");
    zero_inputs();

    // Forwarding select priority
    exe_src2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1; wb_dest = 4'd5; wb_wb_en = 1'b1;
    #1;
`ifdef FORWARDING_EN
    chk("fwd_mem_prio", 8'(fwd_sel2), 8'h01);
`else
    chk("fwd_mem_prio", 8'(fwd_sel2), 8'h00);
`endif
    tick("fwd_mem_prio");
    mem_wb_en = 1'b0;
    #1;
`ifdef FORWARDING_EN
    chk("fwd_wb", 8'(fwd_sel2), 8'h02);
`else
    chk("fwd_wb", 8'(fwd_sel2), 8'h00);
`endif
    tick("fwd_wb");
    zero_inputs();

    // Handshake: ready in the fifth WAIT cycle, taken branch pending throughout
    mem_req = 1'b1; exe_b = 1'b1;
    n_start = 0; n_freeze = 0;
    for (int c = 0; c < 7; c++) begin
      mem_ready = (c == 5);
      #1;
      if (sram_start === 1'b1) n_start++;
      if (freeze_all === 1'b1) n_freeze++;
      chk("hs.flush_gate", 8'(flush), 8'(c == 6));
      tick("hs");
    end
    chk("hs.start_count",  8'(n_start),  8'd1);
    chk("hs.freeze_count", 8'(n_freeze), 8'd6);
    zero_inputs();
    tick("hs_idle");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
      exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
      wb_dest = 4'($urandom_range(0, 3));
      exe_src1 = 4'($urandom_range(0, 3)); exe_src2 = 4'($urandom_range(0, 3));
      id_two_src = 1'($urandom); id_use_src1 = 1'($urandom);
      exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom);
      mem_wb_en = 1'($urandom); wb_wb_en = 1'($urandom);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 4) == 0);
      exe_b = ($urandom_range(0, 3) == 0);
      tick("rand");
    end
    zero_inputs();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick("drain");
    mem_ready = 1'b0;

    // Reset during the third WAIT cycle
    mem_req = 1'b1;
    tick("rstw_issue");
    tick("rstw_wait1");
    tick("rstw_wait2");
    #1;
    chk("rstw.frozen", 8'(freeze_all), 8'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rstw.freeze_drop", 8'(freeze_all), 8'd0);
    tick("rstw_hold");
    rst = 1'b0;
    tick("rstw_reissue");
    mem_req = 1'b0;
    mem_ready = 1'b1;
    tick("rstw_ready");
    mem_ready = 1'b0;
    tick("rstw_done");

    // Timeout: mem_ready never arrives
    mem_req = 1'b1;
    tick("to_issue");
    mem_req = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) tick("to_wait");
    chk("to.flag_set", 8'(mem_timeout), 8'd1);
    chk("to.done_unfrozen", 8'(freeze_all), 8'd0);
    tick("to_done");
    mem_req = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick("to_after");
    zero_inputs();
    chk("to.sticky", 8'(mem_timeout), 8'd1);
    rst = 1'b1;
    model_reset();
    tick("to_clear");
    rst = 1'b0;
    tick("to_cleared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Central sequencing block for the 5-stage ARM pipeline (IF/ID/EXE/MEM/WB). It generates every freeze, flush and bubble control that steers the execute datapath.
- Detects RAW hazards between the ID stage and the EXE/MEM stages and inserts bubbles.
- Applies branch flushes when EXE resolves a taken branch.
- Runs a handshake FSM that freezes the whole pipeline while the MEM stage waits on the multi-cycle SRAM.
- With forwarding compiled in, also drives the EXE operand-forwarding selects.

Parameters:
- TIMEOUT, 64: maximum SRAM wait cycles before the sticky error flag sets.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- id_src1  in  4  ID-stage Rn index
- id_src2  in  4  ID-stage Rm/Rd index
- id_two_src  in  1  ID instruction reads id_src2 (register-shift operand or store)
- id_use_src1  in  1  ID instruction reads id_src1 (0 for MOV/MVN and branches)
- exe_dest  in  4  EXE-stage destination
- exe_wb_en  in  1  EXE-stage instruction writes back
- exe_mem_r_en  in  1  EXE-stage instruction is a load
- exe_src1, exe_src2  in  4 each  source indices latched into ID/EXE (used for forwarding)
- mem_dest  in  4  MEM-stage destination
- mem_wb_en  in  1  MEM-stage write-back enable
- mem_req  in  1  MEM-stage instruction accesses memory (read or write enable)
- mem_ready  in  1  SRAM controller done, single-cycle pulse
- wb_dest  in  4  WB-stage destination
- wb_wb_en  in  1  WB-stage write-back enable
- exe_b  in  1  taken branch resolved in EXE
- sram_start  out  1  one-cycle request pulse to the SRAM controller
- freeze_all  out  1  holds every pipeline register and the PC
- hazard_stall  out  1  freezes PC and IF/ID; inserts a bubble into ID/EXE
- flush  out  1  clears IF/ID and ID/EXE (branch)
- fwd_sel1, fwd_sel2  out  2 each  00 = register file value, 01 = MEM ALU_Res, 10 = WB value
- mem_timeout  out  1  sticky SRAM timeout error

Behaviour:
- FSM states: IDLE, WAIT, DONE. Reset puts the FSM in IDLE, clears the counter and clears mem_timeout.
- IDLE, mem_req=1: sram_start=1 and freeze_all=1 in the same cycle (combinational); next state is WAIT and the counter loads 0.
- WAIT: freeze_all=1 and the counter increments every cycle.
  - mem_ready=1: next state is DONE. freeze_all is still 1 in that cycle.
  - Counter reaches TIMEOUT: mem_timeout sets (sticky until rst) and next state is DONE, so the pipeline never deadlocks.
- DONE: freeze_all=0 for exactly one cycle and mem_req is ignored, so the same memory instruction advances and is not re-issued. Next state is IDLE.
- mem_ready in IDLE or DONE: ignored.
- Hazard match rule: a source matches when its use bit is set, the stage's write-back enable is 1, and the destination equals the index. A match on id_src1 requires id_use_src1; a match on id_src2 requires id_two_src.
- hazard_stall is purely combinational, as follows:
  - Forwarding disabled: a match against EXE or MEM.
  - Forwarding enabled: a match against EXE where exe_mem_r_en=1 (load-use only).
- flush = exe_b.
- Priority: freeze_all > flush > hazard_stall.
  - When freeze_all=1, flush and hazard_stall are forced to 0. Upstream registers hold, so exe_b stays asserted and the flush applies on the first unfrozen cycle.
  - When flush=1, hazard_stall is forced to 0 because the bubble is already being created.
- All outputs are 0 during and immediately after reset, given zero inputs.
- Reset mid-WAIT returns the FSM to IDLE immediately and drops freeze_all asynchronously.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - fwd_sel1 for exe_src1 (and likewise fwd_sel2 for exe_src2): 01 on a match with mem_dest/mem_wb_en; otherwise 10 on a match with wb_dest/wb_wb_en; otherwise 00. MEM has priority over WB.
  - The hazard rule reduces to load-use only.
- Undefined: fwd_sel1 and fwd_sel2 are tied to 00, and the full EXE+MEM stall rule applies. The forwarding input ports remain present and are ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - forwarding select constants FWD_RF, FWD_MEM, FWD_WB;
  - register-index width 4.
- One sub-module, hazard_detect: combinational stall and forwarding logic.
- The FSM and counter stay in the top level.

Test Plan:
- id_src1=3, id_use_src1=1, exe_dest=3, exe_wb_en=1, forwarding off -> hazard_stall=1. Same stimulus with FORWARDING_EN and exe_mem_r_en=0 -> hazard_stall=0.
- Forwarding on: exe_src2=5, mem_dest=5, mem_wb_en=1, wb_dest=5, wb_wb_en=1 -> fwd_sel2=01. Clear mem_wb_en -> fwd_sel2=10.
- mem_req=1 held, mem_ready pulsed 4 cycles after entering WAIT:
  - sram_start high exactly one cycle;
  - freeze_all high 6 cycles (issue cycle + 4 WAIT cycles + ready cycle);
  - then low for the DONE cycle;
  - no second sram_start in DONE.
- exe_b=1 while freeze_all=1 -> flush=0. Once freeze_all drops, flush=1 in that cycle.
- mem_ready never arrives, TIMEOUT=64 -> mem_timeout=1 after 64 WAIT cycles, FSM reaches DONE then IDLE, and mem_timeout stays 1 until rst.
- rst asserted in the 3rd WAIT cycle -> freeze_all=0 immediately; after release, a new mem_req produces sram_start=1.
